decode_sequencer: RTL and testbench

//  Controller for the index-decode datapath. It fetches NUM_IDX indices from an upstream source

---
 rtl/decode_sequencer.sv | 113 +++++++++++
 tb/tb_decode_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_sequencer.sv
// decode_sequencer: fetches NUM_IDX indices, strobes each to the decoder, waits for done with timeout, drives LEDs
//  clk, rst_n                   clock, async active-low reset
//  start                        begin a run (IDLE, SHOW, ERR only)
//  pb                           raw push-button, debounced internally
//  src_idx/src_valid/src_ready  upstream index handshake
//  index_reg/index_reg_valid    index and one-cycle strobe to the decoder
//  dec_done/dec_parity/dec_xored decoder completion and results
//  led                          XOR result, then parity after a press in SHOW; all ones in ERR
//  busy, error                  run in progress, timeout error
module decode_sequencer #(
  parameter int NUM_IDX = 8,
  parameter int IDX_W = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pb,
  input  logic [IDX_W-1:0] src_idx,
  input  logic             src_valid,
  output logic             src_ready,
  output logic [IDX_W-1:0] index_reg,
  output logic             index_reg_valid,
  input  logic             dec_done,
  input  logic             dec_parity,
  input  logic [7:0]       dec_xored,
  output logic [7:0]       led,
  output logic             busy,
  output logic             error
);
  localparam int CW = NUM_IDX > 1 ? $clog2(NUM_IDX) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT_DONE, SHOW, ERR} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] idx_cnt;
  logic [TW-1:0] timer;
  logic [DW-1:0] db_cnt;
  logic res_par, show_parity, pb_s0, pb_s1, pb_db, press;
  logic go, accept, last_idx, timeout_hit;
  always_comb begin
    go = start && (state == IDLE || state == SHOW || state == ERR);
    accept = state == FETCH && src_valid;
    last_idx = idx_cnt == CW'(NUM_IDX - 1);
    timeout_hit = timer == TW'(TIMEOUT_CYCLES - 1);
    src_ready = state == FETCH;
    busy = state == FETCH || state == ISSUE || state == WAIT_DONE;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, SHOW, ERR: state_nxt = start ? FETCH : state;
      FETCH:           state_nxt = src_valid ? ISSUE : FETCH;
      ISSUE:           state_nxt = last_idx ? WAIT_DONE : FETCH;
      // done beats a timeout landing on the same edge
      WAIT_DONE:       state_nxt = dec_done ? SHOW : timeout_hit ? ERR : WAIT_DONE;
      default:         state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_cnt <= '0;
      timer <= '0;
      index_reg <= '0;
      index_reg_valid <= 1'b0;
      res_par <= 1'b0;
      show_parity <= 1'b0;
      led <= 8'h00;
      error <= 1'b0;
    end else begin
      index_reg_valid <= accept;
      error <= state_nxt == ERR;
      if (accept) index_reg <= src_idx;
      if (go) idx_cnt <= '0;
      else if (state == ISSUE && !last_idx) idx_cnt <= idx_cnt + CW'(1);
      if (go || state == ISSUE) timer <= '0;
      else if (state == WAIT_DONE && !timeout_hit) timer <= timer + TW'(1);
      if (state == WAIT_DONE && dec_done) begin
        res_par <= dec_parity;
        led <= dec_xored;
      end else if (state == WAIT_DONE && timeout_hit) led <= 8'hFF;
      if (go) show_parity <= 1'b0;
      else if (state == SHOW && press && !show_parity) begin
        show_parity <= 1'b1;
        led <= {7'b0, res_par};
      end
    end
  end
  // two-flop synchroniser, then a stability counter gating level changes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pb_s0 <= 1'b0;
      pb_s1 <= 1'b0;
      pb_db <= 1'b0;
      db_cnt <= '0;
      press <= 1'b0;
    end else begin
      pb_s0 <= pb;
      pb_s1 <= pb_s0;
      press <= 1'b0;
      if (pb_s1 == pb_db) db_cnt <= '0;
      else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        pb_db <= pb_s1;
        db_cnt <= '0;
        press <= pb_s1;
      end else db_cnt <= db_cnt + DW'(1);
    end
  end
endmodule

// File: tb/tb_decode_sequencer.sv
// tb_decode_sequencer: scoreboard bench for decode_sequencer
module tb_decode_sequencer;
  localparam int NUM_IDX = 8;
  localparam int TMO = 1024;
  logic clk = 0, rst_n = 0, start = 0, pb = 0, src_valid = 0;
  logic dec_done = 0, dec_parity = 0;
  logic [2:0] src_idx = 0;
  logic [7:0] dec_xored = 0;
  logic src_ready, index_reg_valid, busy, error;
  logic [2:0] index_reg;
  logic [7:0] led;
  int vectors = 0, miscompares = 0;
  int cyc = 0, last = -1, mn = 1000, mx = 0, strobes = 0, gap;
  logic [2:0] idx_q[$];
  logic [7:0] res_q[$];
  logic [2:0] mon_exp;

  decode_sequencer #(.NUM_IDX(NUM_IDX), .IDX_W(3), .DEBOUNCE_CYCLES(16), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pb(pb), .src_idx(src_idx), .src_valid(src_valid),
    .src_ready(src_ready), .index_reg(index_reg), .index_reg_valid(index_reg_valid),
    .dec_done(dec_done), .dec_parity(dec_parity), .dec_xored(dec_xored),
    .led(led), .busy(busy), .error(error));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (index_reg_valid) begin
      strobes++;
      vectors++;
      if (idx_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_strobe: index_reg=%0d with nothing pending", index_reg);
      end else begin
        mon_exp = idx_q.pop_front();
        if (index_reg !== mon_exp) begin
          miscompares++;
          $display("FAIL strobe_index: got %0d expected %0d", index_reg, mon_exp);
        end
      end
      if (last >= 0) begin
        gap = cyc - last;
        if (gap < mn) mn = gap;
        if (gap > mx) mx = gap;
      end
      last = cyc;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic run(input int gap_at, input int gap_len, input int done_delay, input logic [7:0] x,
                     input logic p, input int hold_start, input logic [2:0] base);
    logic ok;
    logic [7:0] e;
    int s0;
    @(negedge clk) start = 1;
    @(negedge clk);
    vectors++;
    if (src_ready !== 1'b1 || error !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL run_start: src_ready=%b error=%b busy=%b expected 1 0 1", src_ready, error, busy);
    end
    repeat (hold_start) begin
      @(negedge clk);
      vectors++;
      if (src_ready !== 1'b1 || index_reg_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL start_in_fetch: src_ready=%b strobe=%b expected 1 0", src_ready, index_reg_valid);
      end
    end
    start = 0;
    for (int i = 0; i < NUM_IDX; i++) begin
      if (i == gap_at && gap_len > 0) begin
        src_valid = 0;
        @(negedge clk);
        #1 s0 = strobes;
        repeat (gap_len - 1) @(negedge clk);
        #1 vectors++;
        if (strobes !== s0) begin
          miscompares++;
          $display("FAIL gap_strobe: %0d strobes during gap expected 0", strobes - s0);
        end
      end
      src_idx = base + 3'(i);
      src_valid = 1;
      ok = 0;
      for (int k = 0; k < 50 && !ok; k++) begin
        if (src_ready) ok = 1;
        else @(negedge clk);
      end
      if (!ok) begin
        miscompares++;
        $display("FAIL fetch_timeout: src_ready=%b expected 1 within 50 cycles", src_ready);
        src_valid = 0;
        return;
      end
      idx_q.push_back(src_idx);
      @(negedge clk);
    end
    src_valid = 0;
    if (done_delay < 0) return;
    repeat (done_delay) @(negedge clk);
    dec_done = 1;
    dec_xored = x;
    dec_parity = p;
    res_q.push_back(x);
    @(negedge clk);
    dec_done = 0;
    e = res_q.pop_front();
    vectors++;
    if (led !== e || busy !== 1'b0 || error !== 1'b0) begin
      miscompares++;
      $display("FAIL result: led=%h busy=%b error=%b expected %h 0 0", led, busy, error, e);
    end
    vectors++;
    if (idx_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_idx: %0d indices never strobed expected 0", idx_q.size());
    end
  endtask

  task automatic test_reset();
    #1 vectors++;
    if (led !== 0 || index_reg !== 0 || index_reg_valid !== 0 || src_ready !== 0 || busy !== 0 || error !== 0) begin
      miscompares++;
      $display("FAIL reset: led=%h idx=%0d v=%b rdy=%b busy=%b err=%b expected all 0",
               led, index_reg, index_reg_valid, src_ready, busy, error);
    end
    repeat (3) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_basic();
    int s;
    last = -1; mn = 1000; mx = 0;
    s = strobes;
    run(-1, 0, 3, 8'hA5, 1'b1, 0, 3'd0);
    vectors++;
    if (strobes - s !== NUM_IDX) begin
      miscompares++;
      $display("FAIL strobe_count: got %0d expected %0d", strobes - s, NUM_IDX);
    end
    vectors++;
    if (mn !== 2 || mx !== 2) begin
      miscompares++;
      $display("FAIL strobe_spacing: min=%0d max=%0d expected 2 2", mn, mx);
    end
  endtask

  task automatic press_window(output int changes);
    logic [7:0] prev;
    prev = led;
    changes = 0;
    for (int n = 0; n < 50; n++) begin
      pb = n < 5 ? ~pb : n < 25;
      @(negedge clk);
      if (led !== prev) changes++;
      prev = led;
    end
  endtask

  task automatic test_press();
    int c;
    pb = 0;
    press_window(c);
    vectors++;
    if (c !== 1 || led !== 8'h01) begin
      miscompares++;
      $display("FAIL first_press: led=%h changes=%0d expected 01 1", led, c);
    end
    pb = 0;
    press_window(c);
    vectors++;
    if (c !== 0 || led !== 8'h01) begin
      miscompares++;
      $display("FAIL second_press: led=%h changes=%0d expected 01 0", led, c);
    end
    pb = 0;
  endtask

  task automatic test_ignore();
    @(negedge clk);
    dec_xored = 8'h3C; dec_parity = 0; dec_done = 1;
    repeat (2) @(negedge clk);
    dec_done = 0;
    vectors++;
    if (led !== 8'h01 || busy !== 0 || error !== 0) begin
      miscompares++;
      $display("FAIL done_in_show: led=%h busy=%b error=%b expected 01 0 0", led, busy, error);
    end
    run(-1, 0, 3, 8'h5A, 1'b0, 3, 3'd2);
  endtask

  task automatic test_gap();
    run(4, 10, 3, 8'h3C, 1'b0, 0, 3'd5);
  endtask

  task automatic test_timeout();
    int n;
    logic hit;
    run(-1, 0, -1, 8'h00, 1'b0, 0, 3'd1);
    n = 0; hit = 0;
    for (int k = 0; k < TMO + 100 && !hit; k++) begin
      @(negedge clk);
      if (error) hit = 1;
      else if (busy) n++;
    end
    vectors++;
    if (!hit || n !== TMO) begin
      miscompares++;
      $display("FAIL timeout: error=%b wait_cycles=%0d expected 1 %0d", error, n, TMO);
    end
    vectors++;
    if (led !== 8'hFF || busy !== 0 || src_ready !== 0) begin
      miscompares++;
      $display("FAIL err_state: led=%h busy=%b rdy=%b expected ff 0 0", led, busy, src_ready);
    end
    run(-1, 0, 3, 8'hC3, 1'b1, 0, 3'd0);
  endtask

  task automatic test_reset_mid();
    int s;
    run(-1, 0, -1, 8'h00, 1'b0, 0, 3'd6);
    repeat (5) @(negedge clk);
    #2 rst_n = 0;
    #1 vectors++;
    if (led !== 0 || index_reg !== 0 || index_reg_valid !== 0 || src_ready !== 0 || busy !== 0 || error !== 0) begin
      miscompares++;
      $display("FAIL mid_reset: led=%h idx=%0d v=%b rdy=%b busy=%b err=%b expected all 0",
               led, index_reg, index_reg_valid, src_ready, busy, error);
    end
    repeat (3) @(negedge clk);
    rst_n = 1;
    s = strobes;
    repeat (5) @(negedge clk);
    #1 vectors++;
    if (busy !== 0 || strobes !== s || led !== 0) begin
      miscompares++;
      $display("FAIL post_reset_idle: busy=%b strobes=%0d led=%h expected 0 0 00", busy, strobes - s, led);
    end
    run(-1, 0, 2, 8'h96, 1'b0, 0, 3'd3);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_press();
    test_ignore();
    test_gap();
    test_timeout();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
